// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Rows and columns are active-low; a single pressed key shows as exactly one zero.
package keypad_pkg;

   localparam int KEY_CODE_W = 4;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_PRESSED  = 2'd2,
      ST_RELEASE  = 2'd3
   } kp_state_t;

   localparam logic [3:0] ROW_STROBE [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   localparam logic [3:0] COL_IDLE = 4'hF;

   typedef struct packed {
      logic       valid;
      logic [1:0] idx;
   } col_dec_t;

   // No zero or more than one zero cannot be attributed to one key.
   function automatic col_dec_t col_onehot_to_idx(input logic [3:0] col);
      col_dec_t d;
      d.valid = 1'b1;
      d.idx   = 2'd0;
      case (col)
         4'b1110: d.idx = 2'd0;
         4'b1101: d.idx = 2'd1;
         4'b1011: d.idx = 2'd2;
         4'b0111: d.idx = 2'd3;
         default: d.valid = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin bundle plus the decoded key outputs toward the vending controller.
interface keypad_if;
   import keypad_pkg::*;

   logic [3:0]            linha;
   logic [3:0]            coluna;
   logic [KEY_CODE_W-1:0] key_code;
   logic                  key_valid;
   logic                  key_held;

   modport master (output linha, key_code, key_valid, key_held, input coluna);
   modport slave  (input linha, key_code, key_valid, key_held, output coluna);
endinterface

// File: rtl/keypad_scanner_col_sync.sv
// Two-flop synchroniser for the asynchronous column returns; resets to idle (all-ones).
module keypad_col_sync
   import keypad_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col_async,
   output logic [3:0] col_s
);

   logic [3:0] meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta  <= COL_IDLE;
         col_s <= COL_IDLE;
      end else begin
         meta  <= col_async;
         col_s <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// Row-strobe driver, column debouncer and key-code register for the 4x4 keypad.
//
// state       | meaning
// ST_SCAN     | rotate row strobe, sample columns at the end of each dwell
// ST_DEBOUNCE | row frozen, counting stable cycles of the candidate column
// ST_PRESSED  | key accepted and held, waiting for the pattern to change
// ST_RELEASE  | counting all-ones cycles before declaring the key released
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 255
)(
   input  logic     clk,
   input  logic     rst,
   keypad_if.master kp
);

   localparam int DWELL_W = $clog2(SCAN_DIV);
   localparam int DEB_W   = $clog2(DEBOUNCE + 1);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE - 1);

   kp_state_t state, state_nxt;

   logic [1:0]            row_idx, row_nxt;
   logic [DWELL_W-1:0]    dwell_cnt, dwell_nxt;
   logic [DEB_W-1:0]      deb_cnt, deb_nxt;
   logic [3:0]            cand, cand_nxt;
   logic [1:0]            cand_idx, cand_idx_nxt;
   logic [KEY_CODE_W-1:0] code_q, code_nxt;
   logic                  valid_q, valid_nxt;
   logic                  held_q, held_nxt;

   logic [3:0] col_s;
   col_dec_t   col_dec;
   logic       sample_now, cand_match, col_idle, deb_done;

   keypad_col_sync u_col_sync (
      .clk       (clk),
      .rst       (rst),
      .col_async (kp.coluna),
      .col_s     (col_s)
   );

   assign col_dec    = col_onehot_to_idx(col_s);
   assign sample_now = (dwell_cnt == DWELL_LAST);
   assign cand_match = (col_s == cand);
   assign col_idle   = (col_s == COL_IDLE);
   assign deb_done   = (deb_cnt == DEB_LAST);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_SCAN;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_SCAN:     if (sample_now && col_dec.valid) state_nxt = ST_DEBOUNCE;
         ST_DEBOUNCE: if (!cand_match)                 state_nxt = ST_SCAN;
                      else if (deb_done)               state_nxt = ST_PRESSED;
         ST_PRESSED:  if (!cand_match)                 state_nxt = ST_RELEASE;
         ST_RELEASE:  if (!col_idle)                   state_nxt = ST_PRESSED;
                      else if (deb_done)               state_nxt = ST_SCAN;
         default:                                      state_nxt = ST_SCAN;
      endcase
   end

   always_comb begin
      row_nxt      = row_idx;
      dwell_nxt    = dwell_cnt;
      deb_nxt      = deb_cnt;
      cand_nxt     = cand;
      cand_idx_nxt = cand_idx;
      code_nxt     = code_q;
      valid_nxt    = 1'b0;
      held_nxt     = held_q;
      case (state)
         ST_SCAN: begin
            if (sample_now) begin
               if (col_dec.valid) begin
                  cand_nxt     = col_s;
                  cand_idx_nxt = col_dec.idx;
                  deb_nxt      = '0;
               end else begin
                  row_nxt   = row_idx + 2'd1;
                  dwell_nxt = '0;
               end
            end else begin
               dwell_nxt = dwell_cnt + 1'b1;
            end
         end
         ST_DEBOUNCE: begin
            if (!cand_match) begin
               row_nxt   = row_idx + 2'd1;
               dwell_nxt = '0;
            end else if (deb_done) begin
               code_nxt  = {row_idx, cand_idx};
               valid_nxt = 1'b1;
               held_nxt  = 1'b1;
            end else begin
               deb_nxt = deb_cnt + 1'b1;
            end
         end
         ST_PRESSED: begin
            if (!cand_match) deb_nxt = '0;
         end
         ST_RELEASE: begin
            if (col_idle) begin
               if (deb_done) begin
                  held_nxt  = 1'b0;
                  row_nxt   = row_idx + 2'd1;
                  dwell_nxt = '0;
               end else begin
                  deb_nxt = deb_cnt + 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_idx   <= 2'd0;
         dwell_cnt <= '0;
         deb_cnt   <= '0;
         cand      <= COL_IDLE;
         cand_idx  <= 2'd0;
         code_q    <= '0;
         valid_q   <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         row_idx   <= row_nxt;
         dwell_cnt <= dwell_nxt;
         deb_cnt   <= deb_nxt;
         cand      <= cand_nxt;
         cand_idx  <= cand_idx_nxt;
         code_q    <= code_nxt;
         valid_q   <= valid_nxt;
         held_q    <= held_nxt;
      end
   end

   assign kp.linha     = ROW_STROBE[row_idx];
   assign kp.key_code  = code_q;
   assign kp.key_valid = valid_q;
   assign kp.key_held  = held_q;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Active row-strobe driver and column decoder for the vending-machine 4x4 matrix keypad. It is the driving end of the keypad interface that the vending machine currently only samples. It walks an active-low strobe across the four rows, synchronises and debounces the active-low column returns, and emits one registered key code per physical press. It sits between the keypad pins and the vending-machine controller, which consumes `key_code` qualified by `key_valid`.

## Interface
- `SCAN_DIV`, 1000: clock cycles each row strobe is held (dwell). Minimum 4.
- `DEBOUNCE`, 255: consecutive stable cycles required to accept a press or a release. Minimum 1.
- `clk` in 1: single system clock; all logic is on its rising edge.
- `rst` in 1: synchronous reset, active-high.
- `linha` out 4: row strobes, active-low, one-cold while scanning.
- `coluna` in 4: column returns, active-low, asynchronous to `clk`.
- `key_code` out 4: `{row_idx[1:0], col_idx[1:0]}` of the last accepted key. Row 0 is `linha[0]`; column 0 is `coluna[0]`.
- `key_valid` out 1: one-cycle pulse when `key_code` updates.
- `key_held` out 1: high while an accepted key remains pressed.

## Operation
- `coluna` passes through a 2-flop synchroniser; all logic uses the synchronised value `col_s`.
- FSM states are SCAN, DEBOUNCE, PRESSED and RELEASE.
- **SCAN**
  - `dwell_cnt` counts 0 to SCAN_DIV-1 on the current row.
  - `col_s` is sampled only when `dwell_cnt == SCAN_DIV-1`. This leaves settling time after the strobe change and covers synchroniser delay.
  - If the sample is all-ones, or has more than one zero, the row advances 0→1→2→3→0 (`linha` 1110→1101→1011→0111→1110) and `dwell_cnt` clears.
  - If exactly one zero is present, the FSM latches the candidate column, holds the row and goes to DEBOUNCE with `deb_cnt` = 0.
- **DEBOUNCE**
  - The row stays frozen.
  - Each cycle `col_s` equals the candidate pattern, `deb_cnt` increments.
  - When `deb_cnt` reaches DEBOUNCE-1 on a matching cycle:
    - `key_code` is loaded;
    - `key_valid` pulses on the next cycle;
    - `key_held` goes to 1;
    - the FSM moves to PRESSED.
  - Any mismatch returns the FSM to SCAN, advances to the next row and clears `dwell_cnt`.
- **PRESSED**
  - The row stays frozen.
  - The FSM stays here while `col_s` equals the candidate pattern.
  - Any other value moves the FSM to RELEASE with `deb_cnt` = 0.
- **RELEASE**
  - `deb_cnt` increments while `col_s` is all-ones.
  - Any non-all-ones value returns the FSM to PRESSED with no new `key_valid`.
  - When DEBOUNCE consecutive all-ones cycles have been seen:
    - `key_held` clears to 0;
    - the FSM goes to SCAN on the next row.
- A held key never repeats `key_valid`. Auto-repeat is out of scope.
- A second key pressed on another row while the first is held is ignored. A second key on the same row makes `col_s` differ from the candidate, so the FSM enters RELEASE and then returns to PRESSED if the pattern reverts. No new code is produced.

## Timing
- Reset values:
  - `linha` = 4'b1110;
  - `key_code` = 4'h0;
  - `key_valid` = 0;
  - `key_held` = 0;
  - state = SCAN;
  - all counters and synchroniser flops = 0 / all-ones (columns idle).
- `rst` asserted mid-press forces the reset values on the next edge. A press still held after reset is re-detected through the normal scan and debounce path.
- Press latency, from the column edge to the `key_valid` pulse:
  - 2 cycles of synchroniser delay;
  - plus up to 4·SCAN_DIV cycles until the pressed row is sampled;
  - plus DEBOUNCE cycles;
  - plus 1 cycle for the registered output.
- `key_code` changes only on the cycle `key_valid` is high, and is held otherwise.
- `dwell_cnt` has width $clog2(SCAN_DIV). `deb_cnt` has width $clog2(DEBOUNCE+1). Both saturate and do not wrap inside a state.

## Structure
- Shared package `keypad_pkg` holds:
  - the FSM state enum;
  - the `ROW_STROBE[0:3]` one-cold constants;
  - the `col_onehot_to_idx` function, which returns valid plus a 2-bit index and flags zero or multiple zeros as invalid;
  - the `KEY_CODE_W` = 4 constant.
- One sub-module, `keypad_col_sync`: a 4-bit 2-flop synchroniser with reset value all-ones.

## Test plan
- Reset, then idle columns (4'hF) for 8·SCAN_DIV cycles: `linha` rotates 1110,1101,1011,0111 every SCAN_DIV cycles; no `key_valid`.
- With SCAN_DIV=8 and DEBOUNCE=4, hold `coluna`=1011 while `linha`=1101: exactly one `key_valid` with `key_code`=4'b0110; `key_held`=1 until release plus 4 cycles.
- Bounce `coluna` 1110/1111 every 2 cycles for 20 cycles, then hold 1110: a single `key_valid` only after 4 stable cycles, with `key_code`=4'b00xx matching the strobed row and column 0.
- Drive `coluna`=1100 (two keys): no `key_valid`; scanning continues uninterrupted.
- Assert `rst` while in PRESSED with the key still down: outputs return to reset values next cycle; the key is re-accepted once with a single `key_valid` after the scan and debounce latency.
- Release glitch: in RELEASE, a one-cycle return to the pressed pattern returns the FSM to PRESSED; no second `key_valid`.
